result_tx_framer: RTL and testbench

Packs each SAR conversion result into a fixed byte frame and hands it, one byte at a time, to the UART transmitter. Sits between the SAR FSM and the transmitter. It consumes the SAR end-of-conversion pulse and result word, and drives the transmitter's start strobe and data byte. It paces itself on the transmitter's end-of-transmission pulse so the host receives every conversion as a self-delimiting frame.

---
 rtl/result_tx_framer.sv | 119 +++++++++++
 tb/tb_result_tx_framer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/result_tx_framer.sv
// result_tx_framer
// Packs each SAR conversion result into a fixed byte frame
// (Header, hi, lo[, checksum]) and feeds it one byte at a time to the UART
// transmitter, pacing on the transmitter's end-of-transmission pulse.
// Optional feature macro: RESULT_TX_CHECKSUM_EN appends the checksum byte
// Header ^ hi ^ lo as a fourth byte.

module result_tx_framer #(
   parameter int          Width  = 10,
   parameter logic [7:0]  Header = 8'hA5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [Width-1:0]  result_i,
   input  logic              eot_i,
   output logic              stt_o,
   output logic [7:0]        din_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              drop_o
);

`ifdef RESULT_TX_CHECKSUM_EN
   localparam logic [1:0] LastIndex = 2'd3;
`else
   localparam logic [1:0] LastIndex = 2'd2;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t       state;
   logic [1:0]   index;
   logic [15:0]  ext;
   logic [15:0]  ext_next;

   // Selects the frame byte for a given index from the latched 16-bit word.
   function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [15:0] word);
      logic [7:0] b;
      case (idx)
         2'd0:    b = Header;
         2'd1:    b = word[15:8];
         2'd2:    b = word[7:0];
`ifdef RESULT_TX_CHECKSUM_EN
         default: b = Header ^ word[15:8] ^ word[7:0];
`else
         default: b = 8'h00;
`endif
      endcase
      return b;
   endfunction

   // Zero-extends the incoming result to the 16-bit frame word.
   always_comb begin
      ext_next = '0;
      ext_next[Width-1:0] = result_i;
   end

   // Frame sequencer: latches the result, issues one start strobe per byte
   // and advances only when the transmitter reports the byte is gone.
   // The first byte is loaded on the accepting edge so it appears together
   // with the strobe in the following cycle.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state  <= S_IDLE;
         index  <= 2'd0;
         ext    <= 16'h0000;
         stt_o  <= 1'b0;
         din_o  <= 8'h00;
         busy_o <= 1'b0;
         done_o <= 1'b0;
         drop_o <= 1'b0;
      end else begin
         stt_o  <= 1'b0;
         done_o <= 1'b0;
         drop_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  ext    <= ext_next;
                  index  <= 2'd0;
                  din_o  <= frame_byte(2'd0, ext_next);
                  stt_o  <= 1'b1;
                  busy_o <= 1'b1;
                  state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               drop_o <= start_i;
               state  <= S_WAIT;
            end
            S_WAIT: begin
               drop_o <= start_i;
               if (eot_i) begin
                  if (index == LastIndex) begin
                     done_o <= 1'b1;
                     busy_o <= 1'b0;
                     state  <= S_IDLE;
                  end else begin
                     index <= index + 2'd1;
                     din_o <= frame_byte(index + 2'd1, ext);
                     stt_o <= 1'b1;
                     state <= S_LOAD;
                  end
               end
            end
            default: begin
               busy_o <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_result_tx_framer.sv
// Testbench for result_tx_framer: table-driven cycle vectors followed by
// hand-written multi-cycle sequences. Honours RESULT_TX_CHECKSUM_EN.

module tb_result_tx_framer;

`ifdef RESULT_TX_CHECKSUM_EN
   localparam int        NumBytes = 4;
   localparam logic [7:0] LastByte = 8'h60;
`else
   localparam int        NumBytes = 3;
   localparam logic [7:0] LastByte = 8'hC7;
`endif

   logic        clk;
   logic        rst;
   logic        start;
   logic [9:0]  result;
   logic        eot;
   logic        stt;
   logic [7:0]  din;
   logic        busy;
   logic        done;
   logic        drop;

   int vectors_applied;
   int miscompares;

   typedef struct {
      logic        rst;
      logic        start;
      logic [9:0]  res;
      logic        eot;
      logic        stt;
      logic [7:0]  din;
      logic        busy;
      logic        done;
      logic        drop;
      string       name;
   } vec_t;

   vec_t vecs[$];

   result_tx_framer #(.Width(10), .Header(8'hA5)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .start_i  (start),
      .result_i (result),
      .eot_i    (eot),
      .stt_o    (stt),
      .din_o    (din),
      .busy_o   (busy),
      .done_o   (done),
      .drop_o   (drop)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advances one clock and settles just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compares one value and records the result.
   task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors_applied++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Expected frame byte, hand-derived from the frame definition.
   function automatic logic [7:0] expByte(input logic [9:0] res, input int idx);
      logic [7:0] hi;
      logic [7:0] lo;
      hi = {6'b000000, res[9:8]};
      lo = res[7:0];
      case (idx)
         0:       return 8'hA5;
         1:       return hi;
         2:       return lo;
         default: return 8'hA5 ^ hi ^ lo;
      endcase
   endfunction

   function automatic void addVec(input logic r, input logic s, input logic [9:0] res, input logic e,
                                  input logic xs, input logic [7:0] xd, input logic xb,
                                  input logic xdn, input logic xdr, input string name);
      vec_t v;
      v.rst = r; v.start = s; v.res = res; v.eot = e;
      v.stt = xs; v.din = xd; v.busy = xb; v.done = xdn; v.drop = xdr; v.name = name;
      vecs.push_back(v);
   endfunction

   // Drives one vector's inputs and clocks it in.
   task automatic applyStimulus(input vec_t v);
      rst = v.rst; start = v.start; result = v.res; eot = v.eot;
      tick();
   endtask

   // Compares all outputs against a vector's expectations.
   task automatic checkOutput(input vec_t v);
      checkVal({v.name, ".stt"},  {7'd0, stt},  {7'd0, v.stt});
      checkVal({v.name, ".din"},  din,          v.din);
      checkVal({v.name, ".busy"}, {7'd0, busy}, {7'd0, v.busy});
      checkVal({v.name, ".done"}, {7'd0, done}, {7'd0, v.done});
      checkVal({v.name, ".drop"}, {7'd0, drop}, {7'd0, v.drop});
   endtask

   // Runs a full frame from IDLE with eot returned 'gap' cycles after each
   // strobe; ends in the done cycle.
   task automatic runFrame(input logic [9:0] res, input int gap, input string name);
      int extra;
      start = 1'b1; result = res; tick(); start = 1'b0;
      checkVal({name, ".first_stt"}, {7'd0, stt}, 8'd1);
      checkVal({name, ".first_din"}, din, expByte(res, 0));
      checkVal({name, ".first_busy"}, {7'd0, busy}, 8'd1);
      for (int b = 0; b < NumBytes; b++) begin
         extra = 0;
         for (int i = 1; i < gap; i++) begin
            tick();
            if (stt) extra++;
         end
         checkVal({name, ".extra_stt"}, extra[7:0], 8'd0);
         checkVal({name, ".held_din"}, din, expByte(res, b));
         eot = 1'b1; tick(); eot = 1'b0;
         if (b < NumBytes - 1) begin
            checkVal({name, ".next_stt"}, {7'd0, stt}, 8'd1);
            checkVal({name, ".next_din"}, din, expByte(res, b + 1));
            checkVal({name, ".mid_done"}, {7'd0, done}, 8'd0);
         end else begin
            checkVal({name, ".done"}, {7'd0, done}, 8'd1);
            checkVal({name, ".end_busy"}, {7'd0, busy}, 8'd0);
            checkVal({name, ".end_stt"}, {7'd0, stt}, 8'd0);
         end
      end
   endtask

   // Main test sequence.
   initial begin
      vectors_applied = 0;
      miscompares = 0;
      rst = 1'b0; start = 1'b0; result = 10'h000; eot = 1'b0;

      addVec(0, 1, 10'h2C7, 0, 0, 8'h00, 0, 0, 0, "rst0");
      addVec(0, 1, 10'h2C7, 0, 0, 8'h00, 0, 0, 0, "rst1");
      addVec(0, 1, 10'h2C7, 0, 0, 8'h00, 0, 0, 0, "rst2");
      addVec(1, 1, 10'h2C7, 0, 1, 8'hA5, 1, 0, 0, "accept");
      addVec(1, 0, 10'h000, 1, 0, 8'hA5, 1, 0, 0, "eot_in_load");
      addVec(1, 0, 10'h000, 1, 1, 8'h02, 1, 0, 0, "byte1");
      addVec(1, 1, 10'h3FF, 0, 0, 8'h02, 1, 0, 1, "drop_load");
      addVec(1, 1, 10'h3FF, 0, 0, 8'h02, 1, 0, 1, "drop_wait");
      addVec(1, 0, 10'h000, 1, 1, 8'hC7, 1, 0, 0, "byte2");
      addVec(1, 0, 10'h000, 0, 0, 8'hC7, 1, 0, 0, "wait2");
`ifdef RESULT_TX_CHECKSUM_EN
      addVec(1, 0, 10'h000, 1, 1, 8'h60, 1, 0, 0, "byte3");
      addVec(1, 0, 10'h000, 0, 0, 8'h60, 1, 0, 0, "wait3");
`endif
      addVec(1, 1, 10'h3FF, 1, 0, LastByte, 0, 1, 1, "final_eot_drop");
      addVec(1, 0, 10'h000, 1, 0, LastByte, 0, 0, 0, "eot_in_idle");
      addVec(1, 0, 10'h000, 0, 0, LastByte, 0, 0, 0, "idle_hold");

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i]);
      end

      runFrame(10'h2C7, 20, "basic");
      runFrame(10'h2C7, 20, "start_on_done");
      tick();

      start = 1'b1; result = 10'h2C7; tick(); start = 1'b0;
      tick();
      eot = 1'b1; tick(); eot = 1'b0;
      checkVal("rstmid.byte1_din", din, 8'h02);
      tick();
      tick();
      rst = 1'b0; tick();
      checkVal("rstmid.stt", {7'd0, stt}, 8'd0);
      checkVal("rstmid.busy", {7'd0, busy}, 8'd0);
      checkVal("rstmid.din", din, 8'h00);
      rst = 1'b1; eot = 1'b1; tick(); eot = 1'b0;
      checkVal("rstmid.post_stt", {7'd0, stt}, 8'd0);
      checkVal("rstmid.post_busy", {7'd0, busy}, 8'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkVal("rstmid.quiet_stt", {7'd0, stt}, 8'd0);
      end
      runFrame(10'h001, 3, "after_rst");
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
